usb_rx_data_buffer: RTL

Packet-aware 64-byte receive FIFO directly downstream of `usb_rx`. It captures payload bytes strobed by `store_rx_packet_data`, holds them tentatively until `usb_rx` reports a clean end of packet, then commits them for the AHB-Lite slave side. Errors or overflow roll the packet back, so only whole, good packets are ever visible to the SoC.

---
 rtl/usb_pkg.sv | 14 +
 rtl/usb_fifo_mem.sv | 20 ++
 rtl/usb_rx_data_buffer.sv | 103 ++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: usb_rx status codes, receive buffer sizing defaults and FSM states.
package usb_pkg;
    localparam int DEPTH_DEFAULT  = 64;
    localparam int ADDR_W_DEFAULT = 6;
    localparam logic [2:0] PKT_IDLE  = 3'd0;
    localparam logic [2:0] PKT_IN    = 3'd1;
    localparam logic [2:0] PKT_OUT   = 3'd2;
    localparam logic [2:0] PKT_DATA0 = 3'd3;
    localparam logic [2:0] PKT_DATA1 = 3'd4;
    localparam logic [2:0] PKT_DONE  = 3'd5;
    localparam logic [2:0] PKT_ERROR = 3'd6;
    localparam logic [2:0] PKT_ACK   = 3'd7;
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;
endpackage

// File: rtl/usb_fifo_mem.sv
// usb_fifo_mem: byte register file, one synchronous write port, one combinational read port.
module usb_fifo_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/usb_rx_data_buffer.sv
// usb_rx_data_buffer: packet-aware receive FIFO; bytes stay tentative until a clean
// end of packet commits them, errors and overflow roll the packet back.
module usb_rx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rx_packet,
    input  logic [7:0]        rx_packet_data,
    input  logic              store_rx_packet_data,
    input  logic              get_rx_data,
    input  logic              flush,
    output logic [7:0]        rx_data,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              rx_data_ready,
    output logic              rx_error
);
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

    state_t          r_state;
    logic [2:0]      r_prev_pkt;
    logic [ADDR_W:0] r_wr, r_cm, r_rd;
    logic            r_ovf, r_ready, r_err;
    logic [ADDR_W:0] w_occ, w_used;
    logic            w_evt, w_is_data, w_is_end, w_full, w_pop, w_we;
    logic [7:0]      w_rdata;

    assign w_evt     = rx_packet != r_prev_pkt;
    assign w_is_data = rx_packet == PKT_DATA0 || rx_packet == PKT_DATA1;
    assign w_is_end  = rx_packet == PKT_DONE || rx_packet == PKT_ERROR;
    assign w_occ     = r_cm - r_rd;
    assign w_used    = r_wr - r_rd;
    assign w_full    = w_used == L_DEPTH;
    assign w_pop     = get_rx_data && w_occ != '0 && !flush;
    // A packet-boundary event in RECV takes the cycle; a coincident strobe is not stored.
    assign w_we      = r_state == S_RECV && store_rx_packet_data && !(w_evt && (w_is_end || w_is_data))
                       && !w_full && !flush;

    usb_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr[ADDR_W-1:0]),
        .i_wdata (rx_packet_data),
        .i_raddr (r_rd[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev_pkt <= PKT_IDLE;
            r_wr       <= '0;
            r_cm       <= '0;
            r_rd       <= '0;
            r_ovf      <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_prev_pkt <= rx_packet;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            if (flush) begin
                r_wr    <= '0;
                r_cm    <= '0;
                r_rd    <= '0;
                r_ovf   <= 1'b0;
                r_state <= r_state == S_RECV ? S_DISCARD : S_IDLE;
            end else begin
                if (w_pop) r_rd <= r_rd + L_ONE;
                case (r_state)
                    S_IDLE: if (w_evt && w_is_data) r_state <= S_RECV;
                    S_RECV: begin
                        if (w_evt && rx_packet == PKT_DONE && !r_ovf) begin
                            r_cm    <= r_wr;
                            r_ready <= 1'b1;
                            r_ovf   <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_evt && (w_is_end || w_is_data)) begin
                            r_wr    <= r_cm;
                            r_err   <= 1'b1;
                            r_ovf   <= 1'b0;
                            r_state <= w_is_data ? S_RECV : S_IDLE;
                        end else if (store_rx_packet_data) begin
                            if (w_full) r_ovf <= 1'b1;
                            else r_wr <= r_wr + L_ONE;
                        end
                    end
                    S_DISCARD: if (w_evt && w_is_end) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data          = w_occ != '0 ? w_rdata : 8'h00;
    assign buffer_occupancy = w_occ;
    assign rx_data_ready    = r_ready;
    assign rx_error         = r_err;
endmodule
